sram_arbiter: RTL and testbench

Owns the single external 8-bit asynchronous SRAM and shares it between two requesters. The first is the internal CPU bus, which issues one-cycle rd/wr strobes. The second is an auxiliary master (DMA/SD-to-RAM/video fetch), which uses a req/ack handshake. The arbiter sequences the SRAM control pins with programmable wait states and replaces the direct strobe-to-pin SRAM control in top. The CPU has strict priority, and its worst-case latency is bounded so it always completes inside a V20 bus cycle.

---
 rtl/sram_arbiter_pkg.sv | 28 ++
 rtl/sram_cpu_pending.sv | 44 ++++
 rtl/sram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared encodings and constants for the SRAM arbiter
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD      = 2'd1,
        ST_WR      = 2'd2,
        ST_RECOVER = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_AUX = 1'b1
    } owner_t;

    // SRAM pin levels while nobody owns the bus
    localparam logic SRAM_CE1_IDLE = 1'b1;
    localparam logic SRAM_CE2_IDLE = 1'b0;
    localparam logic SRAM_OE_IDLE  = 1'b1;
    localparam logic SRAM_WE_IDLE  = 1'b1;
    localparam logic SRAM_DIR_IDLE = 1'b0;

    // Wait counter counts down to zero, so it is loaded with wait-1
    function automatic logic [2:0] wait_load(input int unsigned cycles);
        return 3'(cycles - 1);
    endfunction

endpackage

// File: rtl/sram_cpu_pending.sv
// rtl/sram_cpu_pending.sv - one-entry CPU strobe latch with sticky overrun flag
module sram_cpu_pending (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd,
    input  logic        wr,
    input  logic [19:0] addr,
    input  logic [7:0]  data,
    input  logic        take,
    output logic        pending,
    output logic        pend_wr,
    output logic [19:0] pend_addr,
    output logic [7:0]  pend_data,
    output logic        overrun
);

    logic strobe;

    assign strobe = rd | wr;

    // Latch a strobe unless one is already waiting; a consumed strobe (take) is never latched
    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= 1'b0;
            pend_wr   <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
            overrun   <= 1'b0;
        end else begin
            if (strobe && pending) begin
                overrun <= 1'b1;
            end
            if (take) begin
                pending <= 1'b0;
            end else if (strobe && !pending) begin
                pending   <= 1'b1;
                pend_wr   <= wr;
                pend_addr <= addr;
                pend_data <= data;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares the external async SRAM between the CPU bus and an aux master
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_WAIT = 2
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [19:0] iCpuAddr,
    input  logic [7:0]  iCpuData,
    input  logic        iCpuRd,
    input  logic        iCpuWr,
    output logic [7:0]  oCpuData,
    output logic        oCpuValid,
    output logic        oCpuOverrun,
    input  logic        iAuxReq,
    input  logic        iAuxWr,
    input  logic [19:0] iAuxAddr,
    input  logic [7:0]  iAuxData,
    output logic        oAuxAck,
    output logic [7:0]  oAuxData,
    output logic        oAuxValid,
    output logic [19:0] oSramAddr,
    output logic [7:0]  oSramData,
    input  logic [7:0]  iSramData,
    output logic        oSramDir,
    output logic        oSramCe1,
    output logic        oSramCe2,
    output logic        oSramOe,
    output logic        oSramWe
);

    arb_state_t  state, next_state;
    owner_t      owner;
    logic [2:0]  cnt;

    logic        pend_valid, pend_wr;
    logic [19:0] pend_addr;
    logic [7:0]  pend_data;

    logic        cpu_req, cpu_sel_wr;
    logic [19:0] cpu_sel_addr;
    logic [7:0]  cpu_sel_data;
    logic        grant_cpu, grant_aux, grant_wr, wait_done, capture;

    logic        ce_active_nxt, oe_nxt, we_nxt, dir_nxt;
    logic        cpu_valid_nxt, aux_valid_nxt;

    sram_cpu_pending u_pending (
        .clk       (iClk),
        .rst       (iRst),
        .rd        (iCpuRd),
        .wr        (iCpuWr),
        .addr      (iCpuAddr),
        .data      (iCpuData),
        .take      (grant_cpu),
        .pending   (pend_valid),
        .pend_wr   (pend_wr),
        .pend_addr (pend_addr),
        .pend_data (pend_data),
        .overrun   (oCpuOverrun)
    );

    // Request view: a latched CPU entry wins over a fresh strobe; CPU always beats aux
    always_comb begin
        cpu_req      = pend_valid | iCpuRd | iCpuWr;
        cpu_sel_wr   = pend_valid ? pend_wr   : iCpuWr;
        cpu_sel_addr = pend_valid ? pend_addr : iCpuAddr;
        cpu_sel_data = pend_valid ? pend_data : iCpuData;
        grant_cpu    = (state == ST_IDLE) && cpu_req;
        grant_aux    = (state == ST_IDLE) && !cpu_req && iAuxReq;
        grant_wr     = grant_cpu ? cpu_sel_wr : iAuxWr;
        wait_done    = (cnt == 3'd0);
        capture      = (state == ST_RD) && wait_done;
    end

    // State register
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (grant_cpu || grant_aux) begin
                    next_state = grant_wr ? ST_WR : ST_RD;
                end
            end
            ST_RD, ST_WR: begin
                if (wait_done) begin
                    next_state = ST_RECOVER;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Pin and pulse values for the coming cycle; Dir stays up through RECOVER after a write for hold
    always_comb begin
        ce_active_nxt = (next_state != ST_IDLE);
        oe_nxt        = (next_state != ST_RD);
        we_nxt        = (next_state != ST_WR);
        dir_nxt       = (next_state == ST_WR) || (state == ST_WR);
        cpu_valid_nxt = (next_state == ST_RECOVER) && (owner == OWN_CPU);
        aux_valid_nxt = (next_state == ST_RECOVER) && (owner == OWN_AUX);
    end

    // Registered SRAM control pins and handshake pulses
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oSramCe1  <= SRAM_CE1_IDLE;
            oSramCe2  <= SRAM_CE2_IDLE;
            oSramOe   <= SRAM_OE_IDLE;
            oSramWe   <= SRAM_WE_IDLE;
            oSramDir  <= SRAM_DIR_IDLE;
            oCpuValid <= 1'b0;
            oAuxValid <= 1'b0;
            oAuxAck   <= 1'b0;
        end else begin
            oSramCe1  <= !ce_active_nxt;
            oSramCe2  <= ce_active_nxt;
            oSramOe   <= oe_nxt;
            oSramWe   <= we_nxt;
            oSramDir  <= dir_nxt;
            oCpuValid <= cpu_valid_nxt;
            oAuxValid <= aux_valid_nxt;
            oAuxAck   <= grant_aux;
        end
    end

    // Owner, address/data load at grant, wait countdown and read data capture
    always_ff @(posedge iClk) begin
        if (iRst) begin
            owner     <= OWN_CPU;
            cnt       <= 3'd0;
            oSramAddr <= '0;
            oSramData <= '0;
            oCpuData  <= '0;
            oAuxData  <= '0;
        end else begin
            if (grant_cpu) begin
                owner     <= OWN_CPU;
                oSramAddr <= cpu_sel_addr;
                oSramData <= cpu_sel_data;
                cnt       <= cpu_sel_wr ? wait_load(WR_WAIT) : wait_load(RD_WAIT);
            end else if (grant_aux) begin
                owner     <= OWN_AUX;
                oSramAddr <= iAuxAddr;
                oSramData <= iAuxData;
                cnt       <= iAuxWr ? wait_load(WR_WAIT) : wait_load(RD_WAIT);
            end else if ((state == ST_RD || state == ST_WR) && !wait_done) begin
                cnt <= cnt - 3'd1;
            end
            if (capture) begin
                if (owner == OWN_CPU) begin
                    oCpuData <= iSramData;
                end else begin
                    oAuxData <= iSramData;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rd, cpu_wr;
    logic [7:0]  cpu_rdata;
    logic        cpu_valid, overrun;
    logic        aux_req, aux_wr;
    logic [19:0] aux_addr;
    logic [7:0]  aux_wdata;
    logic        aux_ack;
    logic [7:0]  aux_rdata;
    logic        aux_valid;
    logic [19:0] sram_addr;
    logic [7:0]  sram_wdata, sram_rdata;
    logic        sram_dir, sram_ce1, sram_ce2, sram_oe, sram_we;

    always #5 clk = ~clk;

    sram_arbiter #(.RD_WAIT(2), .WR_WAIT(2)) dut (
        .iClk(clk), .iRst(rst),
        .iCpuAddr(cpu_addr), .iCpuData(cpu_wdata), .iCpuRd(cpu_rd), .iCpuWr(cpu_wr),
        .oCpuData(cpu_rdata), .oCpuValid(cpu_valid), .oCpuOverrun(overrun),
        .iAuxReq(aux_req), .iAuxWr(aux_wr), .iAuxAddr(aux_addr), .iAuxData(aux_wdata),
        .oAuxAck(aux_ack), .oAuxData(aux_rdata), .oAuxValid(aux_valid),
        .oSramAddr(sram_addr), .oSramData(sram_wdata), .iSramData(sram_rdata),
        .oSramDir(sram_dir), .oSramCe1(sram_ce1), .oSramCe2(sram_ce2),
        .oSramOe(sram_oe), .oSramWe(sram_we)
    );

    // Async SRAM model with a backdoor preload port
    logic [7:0]  sram_mem [0:1048575];
    logic        pl_en = 1'b0;
    logic [19:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) sram_mem[pl_addr] <= pl_data;
        else if (!sram_we && !sram_ce1 && sram_ce2 && sram_dir) sram_mem[sram_addr] <= sram_wdata;
    end

    assign sram_rdata = (!sram_oe && !sram_ce1 && sram_ce2 && !sram_dir) ? sram_mem[sram_addr] : 8'hEE;

    logic [7:0] ref_mem [0:1048575];

    typedef struct {
        logic       rd;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [19:0] addr;
        logic [7:0]  data;
        logic        preload;
        int          exp_valid;
        logic [7:0]  exp_oe;
        logic [7:0]  exp_we;
        logic [7:0]  exp_dir;
        logic [7:0]  exp_ce;
        logic [7:0]  exp_hold;
    } vec_t;

    exp_t cpu_q[$];
    exp_t aux_q[$];
    vec_t vecs[6];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cpu_valid_cyc, aux_valid_cyc, aux_ack_cyc, ack_count;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock; outputs sampled on the falling edge and scoreboard popped on valid pulses
    task automatic tick();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (aux_ack) begin
            aux_ack_cyc = cyc;
            ack_count++;
        end
        if (cpu_valid) begin
            cpu_valid_cyc = cyc;
            if (cpu_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL cpu_valid_unexpected actual=1 required=0");
            end else begin
                e = cpu_q.pop_front();
                if (e.rd) check("cpu_rdata", {56'd0, cpu_rdata}, {56'd0, e.data});
            end
        end
        if (aux_valid) begin
            aux_valid_cyc = cyc;
            if (aux_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL aux_valid_unexpected actual=1 required=0");
            end else begin
                e = aux_q.pop_front();
                if (e.rd) check("aux_rdata", {56'd0, aux_rdata}, {56'd0, e.data});
            end
        end
    endtask

    task automatic preload(input logic [19:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic push_exp(input logic is_cpu, input logic rd, input logic [7:0] d);
        exp_t e;
        e.rd = rd; e.data = d;
        if (is_cpu) cpu_q.push_back(e); else aux_q.push_back(e);
    endtask

    // CPU access from idle; cycle 1 is the strobe cycle
    task automatic run_vec(input vec_t v, input string tag);
        logic [7:0] oe_m, we_m, dir_m, ce_m;
        int start;
        if (v.preload) preload(v.addr, v.data);
        if (v.wr) begin
            push_exp(1'b1, 1'b0, 8'h00);
            ref_mem[v.addr] = v.data;
        end else begin
            push_exp(1'b1, 1'b1, ref_mem[v.addr]);
        end
        oe_m = '0; we_m = '0; dir_m = '0; ce_m = '0;
        cpu_valid_cyc = -1;
        cpu_addr = v.addr; cpu_wdata = v.data; cpu_rd = !v.wr; cpu_wr = v.wr;
        start = cyc;
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) tick();
            if (k == 2) begin cpu_rd = 1'b0; cpu_wr = 1'b0; end
            oe_m[k]  = !sram_oe;
            we_m[k]  = !sram_we;
            dir_m[k] = sram_dir;
            ce_m[k]  = !sram_ce1 && sram_ce2;
        end
        check({tag, "_valid_cyc"}, 64'(cpu_valid_cyc - start + 1), 64'(v.exp_valid));
        check({tag, "_oe_mask"}, {56'd0, oe_m}, {56'd0, v.exp_oe});
        check({tag, "_we_mask"}, {56'd0, we_m}, {56'd0, v.exp_we});
        check({tag, "_dir_mask"}, {56'd0, dir_m}, {56'd0, v.exp_dir});
        check({tag, "_ce_mask"}, {56'd0, ce_m}, {56'd0, v.exp_ce});
        check({tag, "_cpu_data_hold"}, {56'd0, cpu_rdata}, {56'd0, v.exp_hold});
        if (v.wr) check({tag, "_mem"}, {56'd0, sram_mem[v.addr]}, {56'd0, v.data});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int start, lat;
        // {wr, addr, data, preload, valid_cyc, oe, we, dir, ce, cpu data held afterwards}
        vecs[0] = '{1'b0, 20'h12345, 8'hA5, 1'b1, 4, 8'h0C, 8'h00, 8'h00, 8'h1C, 8'hA5};
        vecs[1] = '{1'b1, 20'hFFFFF, 8'h3C, 1'b0, 4, 8'h00, 8'h0C, 8'h1C, 8'h1C, 8'hA5};
        vecs[2] = '{1'b0, 20'hFFFFF, 8'h00, 1'b0, 4, 8'h0C, 8'h00, 8'h00, 8'h1C, 8'h3C};
        vecs[3] = '{1'b1, 20'h00000, 8'hC3, 1'b0, 4, 8'h00, 8'h0C, 8'h1C, 8'h1C, 8'h3C};
        vecs[4] = '{1'b0, 20'h00000, 8'h00, 1'b0, 4, 8'h0C, 8'h00, 8'h00, 8'h1C, 8'hC3};
        vecs[5] = '{1'b0, 20'h54321, 8'h5A, 1'b1, 4, 8'h0C, 8'h00, 8'h00, 8'h1C, 8'h5A};

        rst = 1'b1;
        cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        aux_req = 1'b0; aux_wr = 1'b0; aux_addr = '0; aux_wdata = '0;
        cpu_valid_cyc = -1; aux_valid_cyc = -1; aux_ack_cyc = -1; ack_count = 0;
        tick(); tick();
        check("reset_state",
              {11'd0, sram_ce1, sram_ce2, sram_oe, sram_we, sram_dir, sram_addr, sram_wdata,
               cpu_rdata, aux_rdata, cpu_valid, aux_valid, aux_ack, overrun},
              {11'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 20'h0, 8'h0, 8'h0, 8'h0, 4'b0000});
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            tick();
        end

        // Aux read granted, CPU strobe arrives the cycle after the grant
        preload(20'h00010, 8'h5A);
        preload(20'h00011, 8'h96);
        aux_req = 1'b1; aux_wr = 1'b0; aux_addr = 20'h00010;
        for (int k = 0; k < 10 && !aux_ack; k++) tick();
        check("contend_ack_seen", {63'd0, aux_ack}, 64'd1);
        push_exp(1'b0, 1'b1, ref_mem[20'h00010]);
        aux_req = 1'b0;
        push_exp(1'b1, 1'b1, ref_mem[20'h00011]);
        cpu_valid_cyc = -1; aux_valid_cyc = -1;
        cpu_addr = 20'h00011; cpu_rd = 1'b1;
        start = cyc;
        tick();
        cpu_rd = 1'b0;
        for (int k = 0; k < 15 && cpu_valid_cyc < 0; k++) tick();
        lat = cpu_valid_cyc - start + 1;
        check("contend_cpu_lat_le8", {63'd0, (cpu_valid_cyc > 0 && lat <= 8)}, 64'd1);
        check("contend_aux_first", {63'd0, (aux_valid_cyc > 0 && aux_valid_cyc < cpu_valid_cyc)}, 64'd1);
        check("contend_aux_data", {56'd0, aux_rdata}, 64'h5A);
        check("contend_cpu_data", {56'd0, cpu_rdata}, 64'h96);
        tick();

        // Same-cycle CPU read and aux write request: CPU first, ack only after CPU RECOVER
        preload(20'h00030, 8'h3E);
        push_exp(1'b1, 1'b1, ref_mem[20'h00030]);
        cpu_valid_cyc = -1; aux_valid_cyc = -1; aux_ack_cyc = -1; ack_count = 0;
        cpu_addr = 20'h00030; cpu_rd = 1'b1;
        aux_req = 1'b1; aux_wr = 1'b1; aux_addr = 20'h00020; aux_wdata = 8'h77;
        start = cyc;
        for (int k = 0; k < 20 && aux_valid_cyc < 0; k++) begin
            tick();
            cpu_rd = 1'b0;
            if (aux_ack) begin
                aux_req = 1'b0;
                push_exp(1'b0, 1'b0, 8'h00);
                ref_mem[20'h00020] = 8'h77;
            end
        end
        check("same_cpu_lat", 64'(cpu_valid_cyc - start + 1), 64'd4);
        check("same_ack_after_cpu", {63'd0, (cpu_valid_cyc > 0 && aux_ack_cyc > cpu_valid_cyc)}, 64'd1);
        check("same_ack_count", 64'(ack_count), 64'd1);
        check("same_aux_done", {63'd0, (aux_valid_cyc > aux_ack_cyc)}, 64'd1);
        check("same_aux_mem", {56'd0, sram_mem[20'h00020]}, 64'h77);
        check("same_cpu_data", {56'd0, cpu_rdata}, 64'h3E);
        tick();

        // Two back-to-back CPU strobes during an aux access: second dropped, overrun sticks
        check("overrun_clear_before", {63'd0, overrun}, 64'd0);
        preload(20'h00040, 8'h44);
        preload(20'h00041, 8'h41);
        preload(20'h00042, 8'h42);
        aux_req = 1'b1; aux_wr = 1'b0; aux_addr = 20'h00040;
        for (int k = 0; k < 10 && !aux_ack; k++) tick();
        check("ovr_ack_seen", {63'd0, aux_ack}, 64'd1);
        aux_req = 1'b0;
        push_exp(1'b0, 1'b1, ref_mem[20'h00040]);
        push_exp(1'b1, 1'b1, ref_mem[20'h00041]);
        cpu_valid_cyc = -1;
        cpu_addr = 20'h00041; cpu_rd = 1'b1;
        tick();
        cpu_addr = 20'h00042;
        tick();
        cpu_rd = 1'b0;
        for (int k = 0; k < 15 && cpu_valid_cyc < 0; k++) tick();
        for (int k = 0; k < 8; k++) tick();
        check("ovr_cpu_data", {56'd0, cpu_rdata}, 64'h41);
        check("ovr_flag_set", {63'd0, overrun}, 64'd1);
        for (int k = 0; k < 5; k++) tick();
        check("ovr_flag_sticky", {63'd0, overrun}, 64'd1);

        // Reset in the middle of a CPU read abandons it without a valid pulse
        preload(20'h00050, 8'h55);
        push_exp(1'b1, 1'b1, ref_mem[20'h00050]);
        cpu_addr = 20'h00050; cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        check("rst_setup_oe_low", {63'd0, sram_oe}, 64'd0);
        rst = 1'b1;
        cpu_q.delete();
        tick();
        check("rst_mid_pins",
              {57'd0, sram_ce1, sram_ce2, sram_oe, sram_dir, cpu_valid, aux_valid, overrun},
              {57'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        check("rst_mid_cpu_data", {56'd0, cpu_rdata}, 64'h0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        v = '{1'b0, 20'h00050, 8'h55, 1'b0, 4, 8'h0C, 8'h00, 8'h00, 8'h1C, 8'h55};
        run_vec(v, "after_rst");

        check("cpu_q_drained", 64'(cpu_q.size()), 64'd0);
        check("aux_q_drained", 64'(aux_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
